// File: rtl/alu_self_test_pkg.sv
// Shared types and constants for the ALU built-in self-test.
// Holds the ALU opcodes, the vector record layout, the fixed 16-entry
// vector table and the self-test FSM state encoding.
package alu_self_test_pkg;

    localparam int unsigned WIDTH       = 32;
    localparam int unsigned NUM_VECTORS = 16;
    localparam int unsigned IDX_W       = $clog2(NUM_VECTORS);
    localparam int unsigned CNT_W       = IDX_W + 1;
    localparam int unsigned CTRL_W      = 3;

    typedef logic [CTRL_W-1:0] alu_ctrl_t;

    localparam alu_ctrl_t ALU_SLT = 3'b000;
    localparam alu_ctrl_t ALU_SUB = 3'b001;
    localparam alu_ctrl_t ALU_ADD = 3'b101;
    localparam alu_ctrl_t ALU_OR  = 3'b110;
    localparam alu_ctrl_t ALU_AND = 3'b111;

    typedef struct packed {
        alu_ctrl_t        ctrl;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] exp_result;
        logic             exp_zero;
    } alu_vector_t;

    localparam alu_vector_t ALU_VECTORS [NUM_VECTORS] = '{
        '{ALU_SLT, 32'd12, 32'd25, 32'd1,          1'b0},
        '{ALU_SLT, 32'd52, 32'd25, 32'd0,          1'b1},
        '{ALU_SLT, 32'd25, 32'd25, 32'd0,          1'b1},
        '{ALU_SUB, 32'd25, 32'd25, 32'd0,          1'b1},
        '{ALU_SUB, 32'd15, 32'd25, 32'hFFFF_FFF6,  1'b0},
        '{ALU_SUB, 32'd25, 32'd15, 32'd10,         1'b0},
        '{ALU_ADD, 32'd25, 32'd25, 32'd50,         1'b0},
        '{ALU_ADD, 32'd0,  32'd25, 32'd25,         1'b0},
        '{ALU_ADD, 32'd25, 32'd0,  32'd25,         1'b0},
        '{ALU_OR,  32'd25, 32'd0,  32'd25,         1'b0},
        '{ALU_OR,  32'd0,  32'd25, 32'd25,         1'b0},
        '{ALU_OR,  32'd0,  32'd0,  32'd0,          1'b1},
        '{ALU_OR,  32'd23, 32'd23, 32'd23,         1'b0},
        '{ALU_AND, 32'd25, 32'd0,  32'd0,          1'b1},
        '{ALU_AND, 32'd0,  32'd25, 32'd0,          1'b1},
        '{ALU_AND, 32'd25, 32'd25, 32'd25,         1'b0}
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/alu_self_test_if.sv
// Bundle between the self-test initiator and the ALU datapath.
//   a, b, alucontrol : operands and opcode into the ALU
//   result, zero     : combinational ALU response
// master = self-test (drives operands), slave = ALU (drives response).
interface alu_self_test_if;
    import alu_self_test_pkg::*;

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    alu_ctrl_t        alucontrol;
    logic [WIDTH-1:0] result;
    logic             zero;

    modport master (output a, output b, output alucontrol, input result, input zero);
    modport slave  (input a, input b, input alucontrol, output result, output zero);
endinterface

// File: rtl/alu_self_test_vector_rom.sv
// Combinational lookup of one self-test vector from the package table.
//   idx_i : vector index
//   vec_o : vector record (opcode, operands, expected result and zero flag)
module alu_vector_rom
    import alu_self_test_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    output alu_vector_t      vec_o
);

    assign vec_o = ALU_VECTORS[idx_i];

endmodule

// File: rtl/alu_self_test.sv
// ALU built-in self-test initiator. On start it walks the 16-entry vector
// table, drives each vector into the ALU for one cycle, checks result/zero in
// the following cycle and reports a pass/fail summary.
//   clk, reset       : clock, synchronous active-high reset
//   start            : run request, honoured only in IDLE or DONE
//   alu              : operand/opcode out, result/zero in (master side)
//   busy, done, pass : run status; done/pass held until next start or reset
//   fail_count       : number of mismatching vectors
//   first_fail_*     : valid flag and index of the first mismatching vector
module alu_self_test
    import alu_self_test_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    alu_self_test_if.master  alu,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_count,
    output logic             first_fail_valid,
    output logic [IDX_W-1:0] first_fail_index
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    alu_ctrl_t        ctrl_q, ctrl_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [CNT_W-1:0] fail_q, fail_d;
    logic             ffv_q, ffv_d;
    logic [IDX_W-1:0] ffi_q, ffi_d;

    alu_vector_t vec_c;
    logic        last_c;
    logic        mismatch_c;

    alu_vector_rom u_rom (
        .idx_i (idx_q),
        .vec_o (vec_c)
    );

    assign last_c     = (idx_q == IDX_W'(NUM_VECTORS - 1));
    assign mismatch_c = (alu.result != vec_c.exp_result) || (alu.zero != vec_c.exp_zero);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = DRIVE;
            DRIVE: state_d = CHECK;
            CHECK: state_d = last_c ? DONE : DRIVE;
            DONE:  if (start) state_d = DRIVE;
        endcase
    end

    // Next values for the registered outputs and counters
    always_comb begin
        idx_d  = idx_q;
        a_d    = a_q;
        b_d    = b_q;
        ctrl_d = ctrl_q;
        busy_d = busy_q;
        done_d = done_q;
        pass_d = pass_q;
        fail_d = fail_q;
        ffv_d  = ffv_q;
        ffi_d  = ffi_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    idx_d  = '0;
                    fail_d = '0;
                    ffv_d  = 1'b0;
                    ffi_d  = '0;
                    done_d = 1'b0;
                    pass_d = 1'b0;
                    busy_d = 1'b1;
                end
            end
            DRIVE: begin
                a_d    = vec_c.a;
                b_d    = vec_c.b;
                ctrl_d = vec_c.ctrl;
            end
            CHECK: begin
                if (mismatch_c) begin
                    fail_d = fail_q + CNT_W'(1);
                    // Only the first mismatch of a run is recorded
                    if (!ffv_q) begin
                        ffv_d = 1'b1;
                        ffi_d = idx_q;
                    end
                end
                if (last_c) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    pass_d = (fail_d == '0);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
        endcase
    end

    // Output and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            ctrl_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
            fail_q <= '0;
            ffv_q  <= 1'b0;
            ffi_q  <= '0;
        end else begin
            idx_q  <= idx_d;
            a_q    <= a_d;
            b_q    <= b_d;
            ctrl_q <= ctrl_d;
            busy_q <= busy_d;
            done_q <= done_d;
            pass_q <= pass_d;
            fail_q <= fail_d;
            ffv_q  <= ffv_d;
            ffi_q  <= ffi_d;
        end
    end

    assign alu.a            = a_q;
    assign alu.b            = b_q;
    assign alu.alucontrol   = ctrl_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign fail_count       = fail_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_index = ffi_q;

endmodule

// File: tb/tb_alu_self_test.sv
// Directed bench for alu_self_test with a behavioural ALU that can be
// switched into faulty modes (OR computed as AND, zero flag stuck at 0).
module tb_alu_self_test;
    import alu_self_test_pkg::*;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             busy, done, pass, first_fail_valid;
    logic [CNT_W-1:0] fail_count;
    logic [IDX_W-1:0] first_fail_index;
    int               fault_mode = 0;
    int               n_tests = 0;
    int               n_fail  = 0;
    logic [WIDTH-1:0] alu_r;

    alu_self_test_if alu_bus ();

    alu_self_test dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .alu              (alu_bus.master),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .fail_count       (fail_count),
        .first_fail_valid (first_fail_valid),
        .first_fail_index (first_fail_index)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: mode 1 turns OR into AND, mode 2 sticks zero at 0
    always_comb begin
        alu_r = '0;
        case (alu_bus.alucontrol)
            ALU_SLT: alu_r = (alu_bus.a < alu_bus.b) ? 32'd1 : 32'd0;
            ALU_SUB: alu_r = alu_bus.a - alu_bus.b;
            ALU_ADD: alu_r = alu_bus.a + alu_bus.b;
            ALU_OR:  alu_r = (fault_mode == 1) ? (alu_bus.a & alu_bus.b) : (alu_bus.a | alu_bus.b);
            ALU_AND: alu_r = alu_bus.a & alu_bus.b;
            default: alu_r = '0;
        endcase
        alu_bus.result = alu_r;
        alu_bus.zero   = (fault_mode == 2) ? 1'b0 : (alu_r == '0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".a"},    alu_bus.a, 32'd0);
        chk({tag, ".b"},    alu_bus.b, 32'd0);
        chk({tag, ".ctrl"}, 32'(alu_bus.alucontrol), 32'd0);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".done"}, 32'(done), 32'd0);
        chk({tag, ".pass"}, 32'(pass), 32'd0);
        chk({tag, ".fcnt"}, 32'(fail_count), 32'd0);
        chk({tag, ".ffv"},  32'(first_fail_valid), 32'd0);
        chk({tag, ".ffi"},  32'(first_fail_index), 32'd0);
    endtask

    // Pulse start at edge T, probe vector 0 and vector 4, then check summary at T+32
    task automatic run(input string tag, input int mode, input int exp_fcnt,
                       input logic exp_ffv, input int exp_ffi, input logic exp_pass);
        fault_mode = mode;
        start = 1'b1;
        tick();                                   // edge T
        start = 1'b0;
        chk({tag, ".busy_T"}, 32'(busy), 32'd1);
        chk({tag, ".done_T"}, 32'(done), 32'd0);
        chk({tag, ".fcnt_T"}, 32'(fail_count), 32'd0);
        tick();                                   // T+1: vector 0 driven
        chk({tag, ".v0_a"},    alu_bus.a, 32'd12);
        chk({tag, ".v0_ctrl"}, 32'(alu_bus.alucontrol), 32'd0);
        repeat (8) tick();                        // T+9: vector 4 driven
        chk({tag, ".v4_a"},    alu_bus.a, 32'd15);
        chk({tag, ".v4_b"},    alu_bus.b, 32'd25);
        chk({tag, ".v4_ctrl"}, 32'(alu_bus.alucontrol), 32'd1);
        chk({tag, ".v4_res"},  alu_bus.result, 32'hFFFF_FFF6);
        repeat (22) tick();                       // T+31
        chk({tag, ".done_T31"}, 32'(done), 32'd0);
        chk({tag, ".busy_T31"}, 32'(busy), 32'd1);
        tick();                                   // T+32
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".pass"}, 32'(pass), 32'(exp_pass));
        chk({tag, ".fcnt"}, 32'(fail_count), 32'(exp_fcnt));
        chk({tag, ".ffv"},  32'(first_fail_valid), 32'(exp_ffv));
        chk({tag, ".ffi"},  32'(first_fail_index), 32'(exp_ffi));
        chk({tag, ".hold_a"},    alu_bus.a, 32'd25);
        chk({tag, ".hold_ctrl"}, 32'(alu_bus.alucontrol), 32'd7);
        tick();
        chk({tag, ".done_held"}, 32'(done), 32'd1);
    endtask

    initial begin
        // Reset
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk_reset_vals("rst");
        tick();
        chk_reset_vals("idle");

        // Correct ALU, then faulty variants restarting from DONE
        run("good",   0, 0, 1'b0, 0, 1'b1);
        run("or_and", 1, 2, 1'b1, 9, 1'b0);
        run("zero0",  2, 6, 1'b1, 1, 1'b0);

        // Reset at T+10 aborts the run with no partial summary
        fault_mode = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_reset_vals("midrst");
        run("after_rst", 0, 0, 1'b0, 0, 1'b1);

        // Start held high: no restart while busy, restart the edge after done
        fault_mode = 1;
        start = 1'b1;
        tick();                                   // T
        repeat (31) tick();                       // T+31
        chk("held.busy_T31", 32'(busy), 32'd1);
        chk("held.done_T31", 32'(done), 32'd0);
        chk("held.a_T31",    alu_bus.a, 32'd25);
        chk("held.ctrl_T31", 32'(alu_bus.alucontrol), 32'd7);
        tick();                                   // T+32
        chk("held.done", 32'(done), 32'd1);
        chk("held.fcnt", 32'(fail_count), 32'd2);
        tick();                                   // T+33: restart sampled
        chk("held.re_done", 32'(done), 32'd0);
        chk("held.re_busy", 32'(busy), 32'd1);
        chk("held.re_fcnt", 32'(fail_count), 32'd0);
        chk("held.re_ffv",  32'(first_fail_valid), 32'd0);
        start = 1'b0;
        tick();
        chk("held.re_v0_a", alu_bus.a, 32'd12);
        chk("held.re_v0_b", alu_bus.b, 32'd25);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
